// File: rtl/hps_ring_pkg.sv
// rtl/hps_ring_pkg.sv - shared constants for the HPS/FPGA ring-buffer controllers
// Purpose: default pointer/data widths, status-word bit positions and drop counter width.
//   The status layout below assumes ADDR_W <= 9 so the pointer field never overlaps the flags.
// Ports: none (package).
package hps_ring_pkg;
  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int DROP_W      = 16;

  localparam int ST_EMPTY    = 9;
  localparam int ST_FULL     = 10;
  localparam int ST_OVF      = 11;
  localparam int ST_PERR     = 12;
  localparam int ST_DROP_LSB = 16;
endpackage

// File: rtl/hps_ring_level.sv
// rtl/hps_ring_level.sv - fill level and full/empty flags of a power-of-two ring
// Purpose: level = (wr_ptr - rd_ptr) mod 2**ADDR_W; one slot is kept unused so
//   level==0 means empty and level==DEPTH-1 means full.
// Ports:
//   wr_ptr  in  ADDR_W  producer pointer (next slot to write)
//   rd_ptr  in  ADDR_W  consumer pointer (next slot to read)
//   level   out ADDR_W  occupied entries
//   empty   out 1       level == 0
//   full    out 1       level == DEPTH-1
module hps_ring_level #(
  parameter int ADDR_W = 9
) (
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] level,
  output logic              empty,
  output logic              full
);
  // Modular subtraction: truncation to ADDR_W bits performs the wrap.
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = &level;
endmodule

// File: rtl/hps_data_out_ringctl.sv
// rtl/hps_data_out_ringctl.sv - FPGA-side producer for the HPS-drained data_out ring
// Purpose: writes an accepted sample stream into an external dual-port RAM, tracks
//   the HPS read pointer, and reports fill, drop, pointer-error and threshold IRQ status.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   enable, clear           capture enable; 1-cycle clear of buffer and sticky status
//   rd_ptr                  HPS read pointer (same clock domain)
//   s_valid/s_data/s_ready  sample input stream
//   ram_we/ram_addr/ram_wdata  RAM write port (combinational, zero latency)
//   irq_ack, irq            IRQ acknowledge pulse and threshold interrupt
//   status                  {drop_cnt, 3'b0, ptr_err, overflow, full, empty, wr_ptr}
module hps_data_out_ringctl
  import hps_ring_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int IRQ_THRESH   = 256,
  parameter int DROP_ON_FULL = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_ptr,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              irq_ack,
  output logic              irq,
  output logic [31:0]       status
);
  localparam bit             DROP_EN = (DROP_ON_FULL != 0);
  localparam logic [ADDR_W:0] THRESH = IRQ_THRESH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] level;
  logic              empty;
  logic              full;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow;
  logic              ptr_err;

  // Previous-cycle snapshot used to spot illegal read-pointer moves.
  logic [ADDR_W-1:0] prev_level;
  logic [ADDR_W-1:0] prev_rd;
  logic              prev_we;
  logic              prev_vld;

  logic wr_fire;
  logic drop_fire;
  logic perr_hit;
  logic level_ge;

  hps_ring_level #(.ADDR_W(ADDR_W)) u_level (
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .level  (level),
    .empty  (empty),
    .full   (full)
  );

  // Clear discards any same-cycle sample without counting it as a drop.
  assign wr_fire   = enable & s_valid & ~full & ~clear;
  assign drop_fire = DROP_EN & enable & s_valid & full & ~clear;
  assign s_ready   = enable & (DROP_EN | ~full);

  assign ram_we    = wr_fire;
  assign ram_addr  = wr_ptr;
  assign ram_wdata = s_data;

  assign level_ge  = ({1'b0, level} >= THRESH);

  // Level can legally grow by at most the one write of the previous cycle; any
  // larger growth coinciding with an rd_ptr change means software moved it
  // backwards or past wr_ptr.
  assign perr_hit  = prev_vld & (rd_ptr != prev_rd) &
                     ({1'b0, level} > ({1'b0, prev_level} + {{ADDR_W{1'b0}}, prev_we}));

  always_comb begin
    status                          = '0;
    status[ADDR_W-1:0]              = wr_ptr;
    status[ST_EMPTY]                = empty;
    status[ST_FULL]                 = full;
    status[ST_OVF]                  = overflow;
    status[ST_PERR]                 = ptr_err;
    status[ST_DROP_LSB +: DROP_W]   = drop_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
      ptr_err    <= 1'b0;
      irq        <= 1'b0;
      prev_level <= '0;
      prev_rd    <= '0;
      prev_we    <= 1'b0;
      prev_vld   <= 1'b0;
    end else begin
      prev_level <= level;
      prev_rd    <= rd_ptr;
      prev_we    <= wr_fire;
      // The cycle after a clear has no meaningful history to compare against.
      prev_vld   <= ~clear;
      if (clear) begin
        wr_ptr   <= rd_ptr;
        drop_cnt <= '0;
        overflow <= 1'b0;
        ptr_err  <= 1'b0;
        irq      <= 1'b0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
        if (drop_fire) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
        if (perr_hit) ptr_err <= 1'b1;
        // Ack wins in its own cycle; the level re-sets irq on the following edge.
        if (irq_ack)       irq <= 1'b0;
        else if (level_ge) irq <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hps_data_out_ringctl.sv
// tb/tb_hps_data_out_ringctl.sv - scoreboard bench for hps_data_out_ringctl (drop and back-pressure builds)
module tb_hps_data_out_ringctl;
  logic        clk = 1'b0;
  logic        reset_n, enable, clear, s_valid, irq_ack;
  logic [8:0]  rd_ptr;
  logic [31:0] s_data;

  logic        sr_d, we_d, irq_d, sr_b, we_b, irq_b;
  logic [8:0]  addr_d, addr_b;
  logic [31:0] wd_d, wd_b, st_d, st_b;

  int total = 0;
  int bad   = 0;
  logic [40:0] exp_q[$];
  logic [8:0]  m_wr;

  always #5 clk = ~clk;

  hps_data_out_ringctl #(.DROP_ON_FULL(1)) u_drop (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .rd_ptr(rd_ptr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(sr_d), .ram_we(we_d), .ram_addr(addr_d),
    .ram_wdata(wd_d), .irq_ack(irq_ack), .irq(irq_d), .status(st_d));

  hps_data_out_ringctl #(.DROP_ON_FULL(0)) u_bp (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .rd_ptr(rd_ptr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(sr_b), .ram_we(we_b), .ram_addr(addr_b),
    .ram_wdata(wd_b), .irq_ack(irq_ack), .irq(irq_b), .status(st_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string nm, input logic [31:0] exp_d, input logic [31:0] exp_b);
    chk({nm, "_st_drop"}, st_d, exp_d);
    chk({nm, "_st_bp"}, st_b, exp_b);
  endtask

  task automatic chk_irq(input string nm, input logic exp);
    chk({nm, "_irq_drop"}, {31'b0, irq_d}, {31'b0, exp});
    chk({nm, "_irq_bp"}, {31'b0, irq_b}, {31'b0, exp});
  endtask

  // One cycle of s_valid; the expected write is queued only if the ring has room.
  task automatic send(input logic [31:0] d);
    logic [8:0] lvl;
    s_valid = 1'b1;
    s_data  = d;
    lvl = m_wr - rd_ptr;
    if (enable && !clear && lvl != 9'h1FF) begin
      exp_q.push_back({m_wr, d});
      m_wr = m_wr + 9'd1;
    end
    tick();
  endtask

  task automatic do_clear();
    s_valid = 1'b0;
    clear   = 1'b1;
    m_wr    = rd_ptr;
    tick();
    clear   = 1'b0;
  endtask

  // Monitor: every RAM write from either build must match the next queued entry.
  always @(negedge clk) begin
    logic [40:0] e;
    if (reset_n && (we_d || we_b)) begin
      chk("we_drop", {31'b0, we_d}, 32'd1);
      chk("we_bp", {31'b0, we_b}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("addr_drop", {23'b0, addr_d}, {23'b0, e[40:32]});
        chk("data_drop", wd_d, e[31:0]);
        chk("addr_bp", {23'b0, addr_b}, {23'b0, e[40:32]});
        chk("data_bp", wd_b, e[31:0]);
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; rd_ptr = 9'd0;
    s_valid = 1'b0; s_data = '0; irq_ack = 1'b0; m_wr = 9'd0;
    repeat (3) tick();
    chk_st("reset", 32'h0000_0200, 32'h0000_0200);
    chk("reset_srdy_drop", {31'b0, sr_d}, 32'd0);
    chk("reset_srdy_bp", {31'b0, sr_b}, 32'd0);
    chk_irq("reset", 1'b0);
    reset_n = 1'b1;
    tick();
    chk_st("post_reset", 32'h0000_0200, 32'h0000_0200);

    // T1: ten samples land at addresses 0..9.
    enable = 1'b1;
    for (int i = 0; i < 10; i++) send(32'hA0 + i);
    s_valid = 1'b0;
    chk_st("t1", 32'h0000_000A, 32'h0000_000A);
    chk("t1_srdy_bp", {31'b0, sr_b}, 32'd1);

    // T2: 510 more samples -> 501 written up to full, 9 dropped in the drop build.
    for (int i = 0; i < 510; i++) send(32'h1000 + i);
    s_valid = 1'b0;
    chk_st("t2_full", 32'h0009_0DFF, 32'h0000_05FF);
    chk("t2_srdy_bp", {31'b0, sr_b}, 32'd0);
    chk("t2_srdy_drop", {31'b0, sr_d}, 32'd1);
    rd_ptr = 9'd100;
    tick();
    chk("t2_srdy_bp_freed", {31'b0, sr_b}, 32'd1);
    chk_st("t2_freed", 32'h0009_09FF, 32'h0000_01FF);
    send(32'h2000);
    send(32'h2001);
    s_valid = 1'b0;
    chk_st("t2_wrap", 32'h0009_0801, 32'h0000_0001);

    // T3: clear, then fill to full and 5 extra -> drop_cnt 5; clear again.
    do_clear();
    chk_st("t3_clear", 32'h0000_0264, 32'h0000_0264);
    chk_irq("t3_clear", 1'b0);
    for (int i = 0; i < 516; i++) send(32'h3000 + i);
    s_valid = 1'b0;
    chk_st("t3_full", 32'h0005_0C63, 32'h0000_0463);
    do_clear();
    chk_st("t3_clear2", 32'h0000_0264, 32'h0000_0264);
    chk_irq("t3_clear2", 1'b0);

    // T4: threshold irq, ack drop-out and re-assertion, ack after level falls.
    for (int i = 0; i < 255; i++) send(32'h4000 + i);
    s_valid = 1'b0;
    tick();
    chk_irq("t4_255", 1'b0);
    send(32'h40FF);
    s_valid = 1'b0;
    tick();
    chk_irq("t4_256", 1'b1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_irq("t4_ack", 1'b0);
    tick();
    chk_irq("t4_rearm", 1'b1);
    rd_ptr = 9'd156;
    tick();
    chk_st("t4_lvl200", 32'h0000_0164, 32'h0000_0164);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_irq("t4_ack200", 1'b0);
    tick();
    chk_irq("t4_stay0", 1'b0);

    // T5: rd_ptr jumps past wr_ptr -> sticky ptr_err until clear.
    rd_ptr = 9'd40;
    do_clear();
    chk_st("t5_clear", 32'h0000_0228, 32'h0000_0228);
    for (int i = 0; i < 10; i++) send(32'h5000 + i);
    s_valid = 1'b0;
    chk_st("t5_wr50", 32'h0000_0032, 32'h0000_0032);
    rd_ptr = 9'd60;
    tick();
    chk_st("t5_perr", 32'h0000_1032, 32'h0000_1032);
    rd_ptr = 9'd50;
    repeat (2) tick();
    chk_st("t5_sticky", 32'h0000_1232, 32'h0000_1232);
    do_clear();
    chk_st("t5_clear2", 32'h0000_0232, 32'h0000_0232);

    // T6: clear wins over a same-cycle sample at level 300; then reset mid-stream.
    for (int i = 0; i < 300; i++) send(32'h6000 + i);
    chk_st("t6_lvl300", 32'h0000_015E, 32'h0000_015E);
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    clear   = 1'b1;
    m_wr    = rd_ptr;
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
    chk_st("t6_clr_win", 32'h0000_0232, 32'h0000_0232);
    chk_irq("t6_clr_win", 1'b0);
    for (int i = 0; i < 5; i++) send(32'h7000 + i);
    s_valid = 1'b0;
    enable  = 1'b0;
    rd_ptr  = 9'd0;
    reset_n = 1'b0;
    m_wr    = 9'd0;
    #2;
    chk_st("t6_in_reset", 32'h0000_0200, 32'h0000_0200);
    chk("t6_srdy_drop", {31'b0, sr_d}, 32'd0);
    chk_irq("t6_in_reset", 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk_st("t6_after_reset", 32'h0000_0200, 32'h0000_0200);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
